serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 160 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents:
//   DEFAULT_WIDTH - default operand/result width
//   state_t       - controller state encoding (IDLE/SHIFT/DONE)
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - c, with borrow out.
// Ports:
//   a      in  minuend bit
//   b      in  subtrahend bit
//   c      in  borrow-in bit
//   diff   out difference bit
//   borrow out borrow-out bit
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ c;
    // Borrow when b exceeds a, or when a equals b and a borrow is pending.
    assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a_in - b_in - bin) mod 2^WIDTH
// LSB-first over WIDTH cycles through a single full_subtractor cell.
// Ports:
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   start      in  request a subtraction (accepted in IDLE or DONE)
//   a_in       in  minuend, captured on accept
//   b_in       in  subtrahend, captured on accept
//   bin        in  borrow-in, captured on accept
//   busy       out high while bits are being processed
//   done       out one-cycle pulse when the result becomes valid
//   diff_out   out result, held until the next completion
//   borrow_out out 1 iff a_in < b_in + bin
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   r_sh_r;
    logic               br_r;
    logic [WIDTH-1:0]   diff_r;
    logic               borrow_r;
    logic               busy_r;
    logic               done_r;
    logic               d_s;
    logic               bo_s;
    logic               load_s;
    logic               shift_s;
    logic               finish_s;

    full_subtractor u_cell (
        .a      (a_sh_r[0]),
        .b      (b_sh_r[0]),
        .c      (br_r),
        .diff   (d_s),
        .borrow (bo_s)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start is deliberately ignored here; operands are not re-sampled.
                shift_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    finish_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Accepting here gives back-to-back jobs every WIDTH+1 cycles.
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operand/result shift registers, borrow flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            r_sh_r <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (load_s) begin
            a_sh_r <= a_in;
            b_sh_r <= b_in;
            r_sh_r <= {WIDTH{1'b0}};
            br_r   <= bin;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (shift_s) begin
            a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
            r_sh_r <= {d_s, r_sh_r[WIDTH-1:1]};
            br_r   <= bo_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end
    end

    // Result registers: updated only on completion, so they hold across a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
        end else if (finish_s) begin
            // The last difference bit has not yet been shifted in, so merge it here.
            diff_r   <= {d_s, r_sh_r[WIDTH-1:1]};
            borrow_r <= bo_s;
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_SHIFT);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff_out   = diff_r;
    assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random
// operands on an 8-bit instance, exhaustive sweep on a 4-bit instance.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;

    int n_cmp;
    int n_err;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a_in       (a8),
        .b_in       (b8),
        .bin        (bin8),
        .busy       (busy8),
        .done       (done8),
        .diff_out   (diff8),
        .borrow_out (borrow8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a_in       (a4),
        .b_in       (b4),
        .bin        (bin4),
        .busy       (busy4),
        .done       (done4),
        .diff_out   (diff4),
        .borrow_out (borrow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {borrow, diff} = {1'b0, a} - b - bin, in WIDTH+1 bit arithmetic.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {8'd0, bi};
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {4'd0, bi};
    endfunction

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] exp;
        int lat;
        int bcnt;
        exp = ref8(a, b, bi);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        bcnt = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'd8);
        check_eq({tag, ".busy_cycles"}, 32'(bcnt), 32'd8);
        check_eq({tag, ".diff"}, 32'(diff8), 32'(exp[7:0]));
        check_eq({tag, ".borrow"}, 32'(borrow8), 32'(exp[8]));
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 32'(done8), 32'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        logic [4:0] exp;
        int lat;
        exp = ref4(a, b, bi);
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("w4.latency", 32'(lat), 32'd4);
        check_eq("w4.diff", 32'(diff4), 32'(exp[3:0]));
        check_eq("w4.borrow", 32'(borrow4), 32'(exp[4]));
    endtask

    initial begin
        int lat;
        int nd;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0;

        // Reset state
        #3;
        check_eq("rst.busy", 32'(busy8), 32'd0);
        check_eq("rst.done", 32'(done8), 32'd0);
        check_eq("rst.diff", 32'(diff8), 32'd0);
        check_eq("rst.borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run8("t1", 8'h05, 8'h03, 1'b0);
        run8("t2a", 8'h00, 8'h01, 1'b0);
        run8("t2b", 8'hFF, 8'hFF, 1'b1);
        run8("t3", 8'h80, 8'h7F, 1'b0);

        // Start ignored while busy, then start held through DONE
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h33; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'h20; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t4.first_latency", 32'(lat), 32'd4);
        check_eq("t4.ignored_diff", 32'(diff8), 32'h0F);
        check_eq("t4.ignored_borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t4.b2b_period", 32'(lat), 32'd9);
        check_eq("t4.b2b_diff", 32'(diff8), 32'h00);
        check_eq("t4.b2b_borrow", 32'(borrow8), 32'd0);

        // Asynchronous reset mid-operation
        run8("t5pre", 8'h05, 8'h03, 1'b0);
        @(negedge clk);
        a8 = 8'h09; b8 = 8'h02; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t5.busy_before", 32'(busy8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5.busy", 32'(busy8), 32'd0);
        check_eq("t5.done", 32'(done8), 32'd0);
        check_eq("t5.diff", 32'(diff8), 32'd0);
        check_eq("t5.borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) nd++;
        end
        check_eq("t5.no_done_after_abort", 32'(nd), 32'd0);
        run8("t5post", 8'h09, 8'h02, 1'b0);

        // Random operands
        for (int i = 0; i < 30; i++) begin
            run8("rand", 8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)));
        end

        // Exhaustive 4-bit sweep
        for (int i = 0; i < 512; i++) begin
            run4(4'(i), 4'(i >> 4), 1'(i >> 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
